i2cmb_wb_sequencer: RTL and testbench

- Wishbone master front-end that turns one high-level I2C transaction request into the register-access sequence the iicmb_m_wb controller requires (CSR/DPR/CMDR).
- Sits between a user/test agent and the I2CMB Wishbone slave port, occupying the wb_if master position.
- Sequence per request: set bus, START, address byte, N data bytes (write or read), STOP.
- Reports NAK, arbitration-lost and error completion status.

---
 rtl/i2cmb_wb_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 tb/tb_i2cmb_wb_sequencer.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_sequencer.sv
// ---------------------------------------------------------------------------------------------
// i2cmb_wb_sequencer
//
// Wishbone master front-end for the iicmb_m_wb I2C controller. One high-level request
// (read/write, bus, slave address, byte count) is expanded into the CSR/DPR/CMDR register
// sequence: enable (first request after reset), set bus, START, address byte, N data bytes,
// STOP. Completion is reported with a one-cycle done_o pulse and a 2-bit status.
//
// Optional feature (macro I2CMB_SEQ_POLL_EN):
//   defined   - completion is detected by polling CMDR every 4 idle cycles, irq disabled
//               (CSR=0x80).
//   undefined - completion is detected by irq_i, then CMDR is read once (CSR=0xC0).
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_valid_i/req_ready_o        request handshake; ready only while idle
//   req_rw_i/bus_i/addr_i/len_i    request fields (len 0 = address-only probe)
//   wr_data_i/wr_valid_i/wr_ready_o  write byte stream; ready pulses on the DPR write ack
//   rd_data_o/rd_valid_o/rd_ready_i  read byte stream; valid held until ready
//   done_o, status_o, busy_o       completion pulse, status (00 OK, 01 NAK, 10 AL, 11 ERR)
//   cyc_o/stb_o/we_o/adr_o/dat_o   Wishbone master outputs
//   dat_i, ack_i                   Wishbone read data and acknowledge
//   irq_i                          controller interrupt request
// ---------------------------------------------------------------------------------------------
module i2cmb_wb_sequencer #(
    parameter int unsigned WB_ADDR_WIDTH  = 2,
    parameter int unsigned WB_DATA_WIDTH  = 8,
    parameter int unsigned NUM_I2C_BUSSES = 1,
    parameter int unsigned LEN_W          = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_rw_i,
    input  logic [7:0]               req_bus_i,
    input  logic [6:0]               req_addr_i,
    input  logic [LEN_W-1:0]         req_len_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    output logic [7:0]               rd_data_o,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic                     done_o,
    output logic [1:0]               status_o,
    output logic                     busy_o,
    output logic                     cyc_o,
    output logic                     stb_o,
    output logic                     we_o,
    output logic [WB_ADDR_WIDTH-1:0] adr_o,
    output logic [WB_DATA_WIDTH-1:0] dat_o,
    input  logic [WB_DATA_WIDTH-1:0] dat_i,
    input  logic                     ack_i,
    input  logic                     irq_i
);

    // Register offsets
    localparam logic [WB_ADDR_WIDTH-1:0] AdrCsr  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] AdrDpr  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] AdrCmdr = WB_ADDR_WIDTH'(2);

    // CMDR command codes
    localparam logic [2:0] CmdWrite   = 3'b001;
    localparam logic [2:0] CmdReadAck = 3'b010;
    localparam logic [2:0] CmdReadNak = 3'b011;
    localparam logic [2:0] CmdStart   = 3'b100;
    localparam logic [2:0] CmdStop    = 3'b101;
    localparam logic [2:0] CmdSetBus  = 3'b110;

`ifdef I2CMB_SEQ_POLL_EN
    localparam logic [7:0] CsrEnable = 8'h80;  // core enable only
`else
    localparam logic [7:0] CsrEnable = 8'hC0;  // core enable + irq enable
`endif

    typedef enum logic [3:0] {
        StIdle,
        StEnable,
        StSetbusDpr,
        StSetbusCmd,
        StStart,
        StAddrDpr,
        StAddrCmd,
        StWrDpr,
        StWrCmd,
        StRdCmd,
        StRdDpr,
        StRdOut,
        StStop,
        StWait,
        StDone
    } state_e;

    // Which command is outstanding while in StWait
    typedef enum logic [2:0] {
        SrcSetbus,
        SrcStart,
        SrcAddr,
        SrcWr,
        SrcRd,
        SrcStop
    } src_e;

    state_e             state_q;
    src_e               src_q;
    logic               enabled_q;
    logic               rw_q;
    logic [7:0]         bus_q;
    logic [6:0]         addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [1:0]         status_q;

`ifdef I2CMB_SEQ_POLL_EN
    logic [1:0]         poll_cnt_q;
    logic               unused_irq;
    assign unused_irq = irq_i;
`endif

    // Access the current state wants to perform once the bus is free
    logic               acc_req;
    logic               acc_we;
    logic [WB_ADDR_WIDTH-1:0] acc_adr;
    logic [7:0]         acc_dat;

    logic               wb_ack;
    logic               last_byte;

    assign wb_ack     = cyc_o & ack_i;
    assign last_byte  = (len_q <= LEN_W'(1));
    assign wr_ready_o = (state_q == StWrDpr) & wb_ack;

    always_comb begin
        acc_req = 1'b0;
        acc_we  = 1'b1;
        acc_adr = AdrCmdr;
        acc_dat = 8'h00;
        case (state_q)
            StEnable: begin
                acc_req = 1'b1;
                acc_adr = AdrCsr;
                acc_dat = CsrEnable;
            end
            StSetbusDpr: begin
                acc_req = 1'b1;
                acc_adr = AdrDpr;
                acc_dat = bus_q;
            end
            StSetbusCmd: begin
                acc_req = 1'b1;
                acc_dat = {5'b0, CmdSetBus};
            end
            StStart: begin
                acc_req = 1'b1;
                acc_dat = {5'b0, CmdStart};
            end
            StAddrDpr: begin
                acc_req = 1'b1;
                acc_adr = AdrDpr;
                acc_dat = {addr_q, rw_q};
            end
            StAddrCmd, StWrCmd: begin
                acc_req = 1'b1;
                acc_dat = {5'b0, CmdWrite};
            end
            StWrDpr: begin
                acc_req = wr_valid_i;
                acc_adr = AdrDpr;
                acc_dat = wr_data_i;
            end
            StRdCmd: begin
                acc_req = 1'b1;
                acc_dat = {5'b0, (last_byte ? CmdReadNak : CmdReadAck)};
            end
            StRdDpr: begin
                acc_req = 1'b1;
                acc_we  = 1'b0;
                acc_adr = AdrDpr;
            end
            StStop: begin
                acc_req = 1'b1;
                acc_dat = {5'b0, CmdStop};
            end
            StWait: begin
`ifdef I2CMB_SEQ_POLL_EN
                acc_req = (poll_cnt_q == 2'd3);
`else
                acc_req = irq_i;
`endif
                acc_we  = 1'b0;
                acc_adr = AdrCmdr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            src_q       <= SrcSetbus;
            enabled_q   <= 1'b0;
            rw_q        <= 1'b0;
            bus_q       <= 8'h00;
            addr_q      <= 7'h00;
            len_q       <= '0;
            status_q    <= 2'b00;
            req_ready_o <= 1'b0;
            rd_data_o   <= 8'h00;
            rd_valid_o  <= 1'b0;
            done_o      <= 1'b0;
            status_o    <= 2'b00;
            busy_o      <= 1'b0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
`ifdef I2CMB_SEQ_POLL_EN
            poll_cnt_q  <= 2'd0;
`endif
        end else begin
            done_o <= 1'b0;

            // Launch only from an idle bus; the ack cycle drops cyc/stb, which guarantees
            // at least one idle cycle before the next access.
            if (acc_req && !cyc_o) begin
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                we_o  <= acc_we;
                adr_o <= acc_adr;
                dat_o <= WB_DATA_WIDTH'(acc_dat);
            end else if (wb_ack) begin
                cyc_o <= 1'b0;
                stb_o <= 1'b0;
                we_o  <= 1'b0;
            end

`ifdef I2CMB_SEQ_POLL_EN
            // Counts idle cycles in WAIT; wraps to 0 on the cycle a CMDR poll is launched.
            if (state_q != StWait) begin
                poll_cnt_q <= 2'd0;
            end else if (!cyc_o) begin
                poll_cnt_q <= poll_cnt_q + 2'd1;
            end
`endif

            case (state_q)
                StIdle: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        rw_q        <= req_rw_i;
                        bus_q       <= req_bus_i;
                        addr_q      <= req_addr_i;
                        len_q       <= req_len_i;
                        status_q    <= 2'b00;
                        if (32'(req_bus_i) >= NUM_I2C_BUSSES) begin
                            // Nonexistent bus: fail without touching the controller
                            status_q <= 2'b11;
                            state_q  <= StDone;
                        end else if (!enabled_q) begin
                            state_q <= StEnable;
                        end else begin
                            state_q <= StSetbusDpr;
                        end
                    end
                end
                StEnable: begin
                    if (wb_ack) begin
                        enabled_q <= 1'b1;
                        state_q   <= StSetbusDpr;
                    end
                end
                StSetbusDpr: begin
                    if (wb_ack) state_q <= StSetbusCmd;
                end
                StSetbusCmd: begin
                    if (wb_ack) begin
                        src_q   <= SrcSetbus;
                        state_q <= StWait;
                    end
                end
                StStart: begin
                    if (wb_ack) begin
                        src_q   <= SrcStart;
                        state_q <= StWait;
                    end
                end
                StAddrDpr: begin
                    if (wb_ack) state_q <= StAddrCmd;
                end
                StAddrCmd: begin
                    if (wb_ack) begin
                        src_q   <= SrcAddr;
                        state_q <= StWait;
                    end
                end
                StWrDpr: begin
                    if (wb_ack) state_q <= StWrCmd;
                end
                StWrCmd: begin
                    if (wb_ack) begin
                        src_q   <= SrcWr;
                        state_q <= StWait;
                    end
                end
                StRdCmd: begin
                    if (wb_ack) begin
                        src_q   <= SrcRd;
                        state_q <= StWait;
                    end
                end
                StRdDpr: begin
                    if (wb_ack) begin
                        rd_data_o  <= dat_i[7:0];
                        rd_valid_o <= 1'b1;
                        state_q    <= StRdOut;
                    end
                end
                StRdOut: begin
                    if (rd_ready_i) begin
                        rd_valid_o <= 1'b0;
                        if (len_q != '0) len_q <= len_q - LEN_W'(1);
                        state_q <= last_byte ? StStop : StRdCmd;
                    end
                end
                StStop: begin
                    if (wb_ack) begin
                        src_q   <= SrcStop;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    // Decode CMDR read-back: ERR > AL > NAK > DON; nothing set keeps waiting.
                    if (wb_ack) begin
                        if (dat_i[4]) begin
                            status_q <= 2'b11;
                            state_q  <= StDone;
                        end else if (dat_i[5]) begin
                            status_q <= 2'b10;
                            state_q  <= StDone;
                        end else if (dat_i[6]) begin
                            status_q <= 2'b01;
                            state_q  <= (src_q == SrcStop) ? StDone : StStop;
                        end else if (dat_i[7]) begin
                            case (src_q)
                                SrcSetbus: state_q <= StStart;
                                SrcStart:  state_q <= StAddrDpr;
                                SrcAddr: begin
                                    if (len_q == '0)  state_q <= StStop;
                                    else if (rw_q)    state_q <= StRdCmd;
                                    else              state_q <= StWrDpr;
                                end
                                SrcWr: begin
                                    if (len_q != '0) len_q <= len_q - LEN_W'(1);
                                    state_q <= last_byte ? StStop : StWrDpr;
                                end
                                SrcRd:   state_q <= StRdDpr;
                                default: state_q <= StDone;
                            endcase
                        end
                    end
                end
                StDone: begin
                    done_o      <= 1'b1;
                    busy_o      <= 1'b0;
                    status_o    <= status_q;
                    req_ready_o <= 1'b1;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_i2cmb_wb_sequencer.sv
`timescale 1ns/1ps
module tb_i2cmb_wb_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rw = 1'b0;
    logic [7:0] req_bus = 8'h00;
    logic [6:0] req_addr = 7'h00;
    logic [7:0] req_len = 8'h00;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       done;
    logic [1:0] status;
    logic       busy;
    logic       cyc, stb, we;
    logic [1:0] adr;
    logic [7:0] dat_o;
    logic [7:0] dat_s;
    logic       ack;
    logic       irq;

    int checks = 0;
    int errors = 0;

`ifdef I2CMB_SEQ_POLL_EN
    localparam int CsrExp = 8'h80;
`else
    localparam int CsrExp = 8'hC0;
`endif

    i2cmb_wb_sequencer dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_rw_i   (req_rw),
        .req_bus_i  (req_bus),
        .req_addr_i (req_addr),
        .req_len_i  (req_len),
        .wr_data_i  (wr_data),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .done_o     (done),
        .status_o   (status),
        .busy_o     (busy),
        .cyc_o      (cyc),
        .stb_o      (stb),
        .we_o       (we),
        .adr_o      (adr),
        .dat_o      (dat_o),
        .dat_i      (dat_s),
        .ack_i      (ack),
        .irq_i      (irq)
    );

    // ---------------- write byte source ----------------
    logic [7:0] wr_bytes [0:31];
    int wr_n = 0;     // written by stimulus only
    int wr_idx = 0;   // advanced by the monitor only
    assign wr_valid = (wr_idx < wr_n);
    assign wr_data  = wr_bytes[wr_idx[4:0]];

    // ---------------- I2CMB slave model ----------------
    logic [9:0] log_q [0:127];   // {adr, data} of every write access
    int         log_n = 0;
    logic [7:0] resp_for [0:7];  // CMDR read-back per issued command code
    logic [7:0] rd_src [0:31];
    int         rd_src_idx = 0;
    logic [7:0] last_resp = 8'h00;
    int         irq_cnt = 0;
    int         cmdr_reads = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack     <= 1'b0;
            irq     <= 1'b0;
            irq_cnt <= 0;
            dat_s   <= 8'h00;
        end else begin
            ack <= 1'b0;
            if (irq_cnt != 0) begin
                irq_cnt <= irq_cnt - 1;
                if (irq_cnt == 1) irq <= 1'b1;
            end
            if (cyc && stb && !ack) begin
                ack <= 1'b1;
                if (we) begin
                    log_q[log_n] <= {adr, dat_o};
                    log_n        <= log_n + 1;
                    if (adr == 2'd2) begin
                        last_resp <= resp_for[dat_o[2:0]];
                        irq_cnt   <= 3;
                    end
                end else if (adr == 2'd2) begin
                    dat_s      <= last_resp;
                    irq        <= 1'b0;
                    cmdr_reads <= cmdr_reads + 1;
                end else if (adr == 2'd1) begin
                    dat_s      <= rd_src[rd_src_idx[4:0]];
                    rd_src_idx <= rd_src_idx + 1;
                end else begin
                    dat_s <= 8'h00;
                end
            end
        end
    end

    // ---------------- output monitor ----------------
    int         done_cnt = 0;
    int         wr_ready_cnt = 0;
    int         rd_got_n = 0;
    logic [1:0] last_status = 2'b00;
    logic [7:0] rd_got [0:31];

    always begin
        @(negedge clk);
        #1;
        if (done === 1'b1) begin
            done_cnt    <= done_cnt + 1;
            last_status <= status;
        end
        if (wr_ready === 1'b1) begin
            wr_ready_cnt <= wr_ready_cnt + 1;
            wr_idx       <= wr_idx + 1;
        end
        if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
            rd_got[rd_got_n[4:0]] <= rd_data;
            rd_got_n              <= rd_got_n + 1;
        end
    end

    function automatic logic [9:0] w(input int a, input int d);
        logic [9:0] r;
        r = {a[1:0], d[7:0]};
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send_req(input logic rw, input logic [7:0] bus, input logic [6:0] a,
                            input logic [7:0] len, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        req_rw    = rw;
        req_bus   = bus;
        req_addr  = a;
        req_len   = len;
        req_valid = ok;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_req(input logic rw, input logic [7:0] bus, input logic [6:0] a,
                           input logic [7:0] len, output bit ok);
        int base;
        bit sent;
        base = done_cnt;
        send_req(rw, bus, a, len, sent);
        if (sent) wait_done(base, ok);
        else ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b expected 0", cyc); end
        checks++; if (stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", stb); end
        checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b expected 00", status); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_write();
        logic [9:0] exp_q[$];
        int lb, wb;
        bit ok;
        exp_q = '{w(0, CsrExp), w(1, 8'h00), w(2, 8'h06), w(2, 8'h04), w(1, 8'h44), w(2, 8'h01),
                  w(1, 8'h05), w(2, 8'h01), w(1, 8'h0A), w(2, 8'h01), w(2, 8'h05)};
        wr_bytes[wr_n[4:0]] = 8'h05;
        wr_bytes[(wr_n + 1) % 32] = 8'h0A;
        wr_n = wr_n + 2;
        lb = log_n;
        wb = wr_ready_cnt;
        run_req(1'b0, 8'h00, 7'h22, 8'd2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL write_done: done_seen=0 expected 1"); end
        checks++; if (log_n - lb !== exp_q.size()) begin errors++; $display("FAIL write_count: got %0d writes expected %0d", log_n - lb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL write_seq[%0d]: got %h expected %h", i, log_q[lb + i], exp_q[i]);
            end
        end
        checks++; if (last_status !== 2'b00) begin errors++; $display("FAIL write_status: got %b expected 00", last_status); end
        checks++; if (wr_ready_cnt - wb !== 2) begin errors++; $display("FAIL write_wr_ready: got %0d expected 2", wr_ready_cnt - wb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy: got %b expected 0", busy); end
    endtask

    task automatic test_read();
        logic [9:0] exp_q[$];
        logic [7:0] exp_rd[3];
        int lb, rb;
        bit ok, seen;
        exp_q = '{w(1, 8'h00), w(2, 8'h06), w(2, 8'h04), w(1, 8'h45), w(2, 8'h01),
                  w(2, 8'h02), w(2, 8'h02), w(2, 8'h03), w(2, 8'h05)};
        exp_rd = '{8'h64, 8'h65, 8'h66};
        for (int i = 0; i < 3; i++) rd_src[(rd_src_idx + i) % 32] = exp_rd[i];
        lb = log_n;
        rb = rd_got_n;
        rd_ready = 1'b0;
        fork
            run_req(1'b1, 8'h00, 7'h22, 8'd3, ok);
            begin
                seen = 1'b0;
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    if (rd_valid === 1'b1) begin
                        seen = 1'b1;
                        break;
                    end
                end
                repeat (5) @(negedge clk);
                checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL read_hold_valid: got %b expected 1 (seen=%0d)", rd_valid, seen); end
                checks++; if (rd_data !== 8'h64) begin errors++; $display("FAIL read_hold_data: got %h expected 64", rd_data); end
                rd_ready = 1'b1;
            end
        join
        checks++; if (!ok) begin errors++; $display("FAIL read_done: done_seen=0 expected 1"); end
        checks++; if (log_n - lb !== exp_q.size()) begin errors++; $display("FAIL read_count: got %0d writes expected %0d", log_n - lb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL read_seq[%0d]: got %h expected %h", i, log_q[lb + i], exp_q[i]);
            end
        end
        checks++; if (rd_got_n - rb !== 3) begin errors++; $display("FAIL read_bytes: got %0d expected 3", rd_got_n - rb); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rd_got[(rb + i) % 32] !== exp_rd[i]) begin
                errors++;
                $display("FAIL read_data[%0d]: got %h expected %h", i, rd_got[(rb + i) % 32], exp_rd[i]);
            end
        end
        checks++; if (last_status !== 2'b00) begin errors++; $display("FAIL read_status: got %b expected 00", last_status); end
    endtask

    task automatic test_addr_nak();
        logic [9:0] exp_q[$];
        int lb, wb;
        bit ok;
        exp_q = '{w(1, 8'h00), w(2, 8'h06), w(2, 8'h04), w(1, 8'h44), w(2, 8'h01), w(2, 8'h05)};
        for (int i = 0; i < 4; i++) wr_bytes[(wr_n + i) % 32] = 8'hA0 + 8'(i);
        wr_n = wr_n + 4;
        resp_for[1] = 8'h40;
        lb = log_n;
        wb = wr_ready_cnt;
        run_req(1'b0, 8'h00, 7'h22, 8'd4, ok);
        resp_for[1] = 8'h80;
        checks++; if (!ok) begin errors++; $display("FAIL nak_done: done_seen=0 expected 1"); end
        checks++; if (log_n - lb !== exp_q.size()) begin errors++; $display("FAIL nak_count: got %0d writes expected %0d", log_n - lb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL nak_seq[%0d]: got %h expected %h", i, log_q[lb + i], exp_q[i]);
            end
        end
        checks++; if (wr_ready_cnt !== wb) begin errors++; $display("FAIL nak_wr_ready: got %0d pulses expected 0", wr_ready_cnt - wb); end
        checks++; if (status !== 2'b01) begin errors++; $display("FAIL nak_status: got %b expected 01", status); end
        wr_n = wr_idx;
    endtask

    task automatic test_arb_lost();
        int lb;
        bit ok;
        resp_for[4] = 8'h20;
        lb = log_n;
        run_req(1'b0, 8'h00, 7'h22, 8'd1, ok);
        resp_for[4] = 8'h80;
        checks++; if (!ok) begin errors++; $display("FAIL al_done: done_seen=0 expected 1"); end
        checks++; if (log_n - lb !== 3) begin errors++; $display("FAIL al_count: got %0d writes expected 3", log_n - lb); end
        checks++; if (log_q[lb + 2] !== w(2, 8'h04)) begin errors++; $display("FAIL al_last: got %h expected %h", log_q[lb + 2], w(2, 8'h04)); end
        checks++; if (last_status !== 2'b10) begin errors++; $display("FAIL al_status: got %b expected 10", last_status); end
    endtask

    task automatic test_probe_busy();
        logic [9:0] exp_q[$];
        int lb, db, cr;
        bit sent, ok;
        exp_q = '{w(1, 8'h00), w(2, 8'h06), w(2, 8'h04), w(1, 8'h20), w(2, 8'h01), w(2, 8'h05)};
        lb = log_n;
        db = done_cnt;
        cr = cmdr_reads;
        send_req(1'b0, 8'h00, 7'h10, 8'd0, sent);
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL probe_busy: got %b expected 1", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL probe_req_ready: got %b expected 0", req_ready); end
        // A second request while busy must be dropped
        req_addr  = 7'h33;
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        req_valid = 1'b0;
        if (sent) wait_done(db, ok);
        else ok = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL probe_done: done_seen=0 expected 1"); end
        checks++; if (log_n - lb !== exp_q.size()) begin errors++; $display("FAIL probe_count: got %0d writes expected %0d", log_n - lb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL probe_seq[%0d]: got %h expected %h", i, log_q[lb + i], exp_q[i]);
            end
        end
        checks++; if (last_status !== 2'b00) begin errors++; $display("FAIL probe_status: got %b expected 00", last_status); end
        checks++; if (cmdr_reads - cr !== 4) begin errors++; $display("FAIL probe_cmdr_reads: got %0d expected 4", cmdr_reads - cr); end
        repeat (50) @(negedge clk);
        checks++; if (done_cnt - db !== 1) begin errors++; $display("FAIL probe_single_done: got %0d expected 1", done_cnt - db); end
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp_q[$];
        int lb, db;
        bit sent, found, ok;
        exp_q = '{w(0, CsrExp), w(1, 8'h00), w(2, 8'h06), w(2, 8'h04), w(1, 8'h20), w(2, 8'h01),
                  w(2, 8'h05)};
        wr_bytes[wr_n[4:0]] = 8'h05;
        wr_bytes[(wr_n + 1) % 32] = 8'h0A;
        wr_n = wr_n + 2;
        db = done_cnt;
        send_req(1'b0, 8'h00, 7'h22, 8'd2, sent);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cyc === 1'b1 && we === 1'b1 && adr === 2'd1 && dat_o === 8'h05) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL rst_mid_reach: data_phase_seen=0 expected 1 (sent=%0d)", sent); end
        rst_n = 1'b0;
        #1;
        checks++; if (cyc !== 1'b0) begin errors++; $display("FAIL rst_mid_cyc: got %b expected 0", cyc); end
        checks++; if (stb !== 1'b0) begin errors++; $display("FAIL rst_mid_stb: got %b expected 0", stb); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        repeat (5) @(negedge clk);
        checks++; if (done_cnt !== db) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt - db); end
        rst_n = 1'b1;
        wr_n = wr_idx;
        lb = log_n;
        run_req(1'b0, 8'h00, 7'h10, 8'd0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_next_done: done_seen=0 expected 1"); end
        checks++; if (log_n - lb !== exp_q.size()) begin errors++; $display("FAIL rst_next_count: got %0d writes expected %0d", log_n - lb, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rst_next_seq[%0d]: got %h expected %h", i, log_q[lb + i], exp_q[i]);
            end
        end
        checks++; if (status !== 2'b00) begin errors++; $display("FAIL rst_next_status: got %b expected 00", status); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) resp_for[i] = 8'h80;
        for (int i = 0; i < 32; i++) begin
            wr_bytes[i] = 8'h00;
            rd_src[i]   = 8'h00;
        end
        test_reset();
        test_write();
        test_read();
        test_addr_nak();
        test_arb_lost();
        test_probe_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
